user_hs_loopback_fifo: RTL and testbench
========================================

// Module: user_hs_loopback_fifo
// PURPOSE
//  User-clock endpoint for one leaf interface port pair, i.e. the operator side of the ap_vld/ap_ack handshake.
//  - Receives words the leaf interface delivers to the user (leaf->user stream).
//  - Buffers them in a first-word-fall-through FIFO.
//  - Retransmits them, in order, on the user->leaf stream.
//  - Used as a loopback/stub operator for bring-up, and as a rate-decoupling buffer in front of HLS operators.
// PARAMETERS
//  PAYLOAD_BITS   32  width of one data word
//  DEPTH_BITS     4   log2 of FIFO depth (depth = 2**DEPTH_BITS = 16)
//  CNT_BITS       32  width of the rx/tx transfer counters
// PORTS
//  clk_user                 in   1             user clock; all logic in this one domain
//  reset                    in   1             asynchronous, active-high reset
//  din_leaf_interface2user  in   PAYLOAD_BITS  word from leaf interface
//  vld_interface2user       in   1             din valid
//  ack_user2interface       out  1             this block accepts din
//  dout_user2interface      out  PAYLOAD_BITS  word to leaf interface
//  vld_user2interface       out  1             dout valid
//  ack_interface2user       in   1             leaf interface accepts dout
//  fifo_count               out  DEPTH_BITS+1  words currently buffered (0..2**DEPTH_BITS)
//  rx_count                 out  CNT_BITS      words accepted since reset
//  tx_count                 out  CNT_BITS      words sent since reset
// BEHAVIOUR
//  Handshake rules (both streams)
//  - A transfer occurs on a rising clk_user edge where vld && ack are both 1.
//  - A source holding vld=1 keeps data stable until the transfer. vld never depends combinationally on ack.
//  - ack may be asserted with vld=0. Nothing transfers in that case.
//  Receive side
//  - ack_user2interface = (fifo_count != DEPTH). Combinational from registered count only.
//  - When full, ack is 0 even if a pop happens in the same cycle. No bypass; a full FIFO accepts again one cycle after the pop.
//  - push = vld_interface2user && ack_user2interface. Writes mem[wr_ptr]; wr_ptr increments.
//  Transmit side
//  - vld_user2interface = (fifo_count != 0).
//  - dout_user2interface = mem[rd_ptr] (FWFT head); stable while vld=1 and ack=0.
//  - pop = vld_user2interface && ack_interface2user; rd_ptr increments.
//  Latency
//  - A word written into an empty FIFO at edge N is presented with vld=1 immediately after edge N.
//  - The earliest transmit is therefore at edge N+1 (one-cycle min latency).
//  Pointers and counts
//  - wr_ptr/rd_ptr are DEPTH_BITS wide and wrap modulo depth.
//  - fifo_count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop (allowed whenever 0 < count < DEPTH).
//  - Push at count 0 with no pop: count becomes 1; the pop cannot coincide because vld was 0.
//  - rx_count +1 per push, tx_count +1 per pop. Both wrap modulo 2**CNT_BITS with no saturation.
//  - Invariant: rx_count - tx_count == fifo_count, modulo 2**CNT_BITS.
//  Reset
//  - Asynchronous assert: ptrs, fifo_count, rx_count, tx_count := 0.
//  - Outputs then: ack_user2interface=1, vld_user2interface=0, dout_user2interface=0 (mem[0] read through a reset-cleared output mux).
//  - Memory contents are not reset.
//  - Reset mid-transfer discards all buffered words; no partial word is ever emitted.
//  - Deassertion is expected synchronous to clk_user, provided by the existing reset synchroniser.
//  Data is never reordered, duplicated or dropped while reset is low.
// TESTING
//  1. Reset: assert reset asynchronously mid-cycle -> same instant vld_user2interface=0, ack_user2interface=1, all counts=0.
//  2. Single word, ack_interface2user=1: push 0xDEADBEEF at edge 5.
//     -> vld_user2interface=1, dout=0xDEADBEEF after edge 5; popped at edge 6; tx_count=1.
//  3. Fill, ack_interface2user=0: push 16 words 0..15 -> fifo_count=16 and ack_user2interface=0.
//     - A 17th word held with vld=1 is not accepted; rx_count stays 16.
//  4. Full plus simultaneous pop: from full, raise ack_interface2user for one cycle -> word 0 pops, count=15.
//     - Next edge, the 17th word (0x10) is accepted; order out is 1..15, then 0x10.
//  5. Streaming: vld_interface2user and ack_interface2user both 1 for 1000 cycles, data = incrementing.
//     - Count stays <=1; output equals input delayed 1 cycle.
//     - rx_count=tx_count+fifo_count at every edge.
//  6. Random stall: 10k cycles of random vld/ack on both sides, plus a reset pulse at cycle 5000.
//     - Scoreboard matches in order; no word entered before the reset appears after it.
//     - Pointer wrap is exercised >100 times.

Source files
------------

// File: rtl/user_hs_loopback_fifo.sv
// User-side loopback endpoint: words accepted on the leaf->user stream are buffered
// in a first-word-fall-through FIFO and replayed, in order, on the user->leaf stream.
module user_hs_loopback_fifo #(
  parameter int PAYLOAD_BITS = 32,
  parameter int DEPTH_BITS   = 4,
  parameter int CNT_BITS     = 32
) (
  input  logic                    clk_user,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] din_leaf_interface2user,
  input  logic                    vld_interface2user,
  output logic                    ack_user2interface,
  output logic [PAYLOAD_BITS-1:0] dout_user2interface,
  output logic                    vld_user2interface,
  input  logic                    ack_interface2user,
  output logic [DEPTH_BITS:0]     fifo_count,
  output logic [CNT_BITS-1:0]     rx_count,
  output logic [CNT_BITS-1:0]     tx_count
);

  // Handshake: a word moves on a rising clk_user edge where vld && ack are both 1;
  // a source holds data stable while vld=1, and vld never depends on ack combinationally.

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_COUNT = {1'b1, {DEPTH_BITS{1'b0}}};

  logic [PAYLOAD_BITS-1:0] mem [DEPTH];
  logic [DEPTH_BITS-1:0]   wr_ptr;
  logic [DEPTH_BITS-1:0]   rd_ptr;
  logic                    push;
  logic                    pop;

  // Both flags come from the registered count only: a full FIFO does not accept
  // in the same cycle it pops, so there is no combinational ack path.
  assign ack_user2interface  = (fifo_count != FULL_COUNT);
  assign vld_user2interface  = (fifo_count != '0);
  assign dout_user2interface = vld_user2interface ? mem[rd_ptr] : '0;

  assign push = vld_interface2user && ack_user2interface;
  assign pop  = vld_user2interface && ack_interface2user;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_user) begin
    if (push) begin
      mem[wr_ptr] <= din_leaf_interface2user;
    end
  end

  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rx_count   <= '0;
      tx_count   <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        rx_count <= rx_count + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        tx_count <= tx_count + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_user_hs_loopback_fifo.sv
// Randomized and directed bench for user_hs_loopback_fifo against a queue-based
// model of the FIFO's transfer rules.
`timescale 1ns/1ps
module tb_user_hs_loopback_fifo;

  logic        clk_user;
  logic        reset;
  logic [31:0] din_leaf_interface2user;
  logic        vld_interface2user;
  logic        ack_user2interface;
  logic [31:0] dout_user2interface;
  logic        vld_user2interface;
  logic        ack_interface2user;
  logic [4:0]  fifo_count;
  logic [31:0] rx_count;
  logic [31:0] tx_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] m_rx;
  logic [31:0] m_tx;
  int          pop_total;

  user_hs_loopback_fifo #(
    .PAYLOAD_BITS(32),
    .DEPTH_BITS(4),
    .CNT_BITS(32)
  ) dut (
    .clk_user(clk_user),
    .reset(reset),
    .din_leaf_interface2user(din_leaf_interface2user),
    .vld_interface2user(vld_interface2user),
    .ack_user2interface(ack_user2interface),
    .dout_user2interface(dout_user2interface),
    .vld_user2interface(vld_user2interface),
    .ack_interface2user(ack_interface2user),
    .fifo_count(fifo_count),
    .rx_count(rx_count),
    .tx_count(tx_count)
  );

  // clock / reset
  initial begin
    clk_user = 1'b0;
    forever #5 clk_user = ~clk_user;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Advance one edge and apply the transfer rules to the model; returns #1 after the edge.
  task automatic tick();
    bit do_push;
    bit do_pop;
    @(posedge clk_user);
    do_push = vld_interface2user && (exp_q.size() != 16);
    do_pop  = ack_interface2user && (exp_q.size() != 0);
    if (do_pop) begin
      void'(exp_q.pop_front());
      m_tx = m_tx + 1;
      pop_total++;
    end
    if (do_push) begin
      exp_q.push_back(din_leaf_interface2user);
      m_rx = m_rx + 1;
    end
    #1;
  endtask

  // Mid-cycle asynchronous reset pulse; buffered words are discarded.
  task automatic do_reset();
    @(posedge clk_user);
    #3 reset = 1'b1;
    #1 reset = 1'b0;
    exp_q.delete();
    m_rx = 0;
    m_tx = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    vld_interface2user = 1'b0;
    ack_interface2user = 1'b0;
    din_leaf_interface2user = '0;
    #1;
    checks++;
    if (vld_user2interface !== 1'b0 || ack_user2interface !== 1'b1 || fifo_count !== 5'd0 ||
        rx_count !== 32'd0 || tx_count !== 32'd0 || dout_user2interface !== 32'd0) begin
      failures++;
      $display("FAIL reset_initial: vld=%b ack=%b cnt=%0d rx=%0d tx=%0d dout=%h want 0 1 0 0 0 0",
               vld_user2interface, ack_user2interface, fifo_count, rx_count, tx_count, dout_user2interface);
    end
    @(posedge clk_user);
    #1 reset = 1'b0;
    exp_q.delete(); m_rx = 0; m_tx = 0;
    for (int i = 0; i < 3; i++) begin
      vld_interface2user = 1'b1;
      din_leaf_interface2user = 32'h100 + i;
      tick();
    end
    vld_interface2user = 1'b0;
    checks++;
    if (fifo_count !== 5'd3 || rx_count !== 32'd3) begin
      failures++;
      $display("FAIL reset_prefill: cnt=%0d rx=%0d want 3 3", fifo_count, rx_count);
    end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (vld_user2interface !== 1'b0 || ack_user2interface !== 1'b1 || fifo_count !== 5'd0 ||
        rx_count !== 32'd0 || tx_count !== 32'd0 || dout_user2interface !== 32'd0) begin
      failures++;
      $display("FAIL reset_async: vld=%b ack=%b cnt=%0d rx=%0d tx=%0d dout=%h want 0 1 0 0 0 0",
               vld_user2interface, ack_user2interface, fifo_count, rx_count, tx_count, dout_user2interface);
    end
    reset = 1'b0;
    exp_q.delete(); m_rx = 0; m_tx = 0;
  endtask

  task automatic test_single();
    do_reset();
    ack_interface2user = 1'b1;
    vld_interface2user = 1'b1;
    din_leaf_interface2user = 32'hDEADBEEF;
    tick();
    vld_interface2user = 1'b0;
    din_leaf_interface2user = '0;
    checks++;
    if (vld_user2interface !== 1'b1 || dout_user2interface !== 32'hDEADBEEF || fifo_count !== 5'd1) begin
      failures++;
      $display("FAIL single_present: vld=%b dout=%h cnt=%0d want 1 deadbeef 1",
               vld_user2interface, dout_user2interface, fifo_count);
    end
    tick();
    checks++;
    if (vld_user2interface !== 1'b0 || tx_count !== 32'd1 || rx_count !== 32'd1 || fifo_count !== 5'd0) begin
      failures++;
      $display("FAIL single_pop: vld=%b tx=%0d rx=%0d cnt=%0d want 0 1 1 0",
               vld_user2interface, tx_count, rx_count, fifo_count);
    end
    ack_interface2user = 1'b0;
  endtask

  task automatic test_fill_and_full_pop();
    do_reset();
    ack_interface2user = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vld_interface2user = 1'b1;
      din_leaf_interface2user = i;
      tick();
    end
    checks++;
    if (fifo_count !== 5'd16 || ack_user2interface !== 1'b0 || dout_user2interface !== 32'd0) begin
      failures++;
      $display("FAIL fill_full: cnt=%0d ack=%b head=%h want 16 0 0",
               fifo_count, ack_user2interface, dout_user2interface);
    end
    din_leaf_interface2user = 32'h10;
    tick();
    checks++;
    if (rx_count !== 32'd16 || fifo_count !== 5'd16) begin
      failures++;
      $display("FAIL fill_17th_blocked: rx=%0d cnt=%0d want 16 16", rx_count, fifo_count);
    end
    ack_interface2user = 1'b1;
    tick();
    ack_interface2user = 1'b0;
    checks++;
    if (fifo_count !== 5'd15 || rx_count !== 32'd16 || tx_count !== 32'd1 || ack_user2interface !== 1'b1) begin
      failures++;
      $display("FAIL full_pop_no_bypass: cnt=%0d rx=%0d tx=%0d ack=%b want 15 16 1 1",
               fifo_count, rx_count, tx_count, ack_user2interface);
    end
    tick();
    vld_interface2user = 1'b0;
    checks++;
    if (fifo_count !== 5'd16 || rx_count !== 32'd17) begin
      failures++;
      $display("FAIL full_pop_accept_next: cnt=%0d rx=%0d want 16 17", fifo_count, rx_count);
    end
    ack_interface2user = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      checks++;
      if (vld_user2interface !== 1'b1 || dout_user2interface !== i) begin
        failures++;
        $display("FAIL drain_order[%0d]: vld=%b dout=%h want 1 %h", i, vld_user2interface, dout_user2interface, i);
      end
      tick();
    end
    checks++;
    if (vld_user2interface !== 1'b0 || tx_count !== 32'd17) begin
      failures++;
      $display("FAIL drain_empty: vld=%b tx=%0d want 0 17", vld_user2interface, tx_count);
    end
    ack_interface2user = 1'b0;
  endtask

  task automatic test_streaming();
    logic [31:0] base;
    do_reset();
    base = $urandom;
    vld_interface2user = 1'b1;
    ack_interface2user = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      din_leaf_interface2user = base + i;
      tick();
      checks++;
      if (vld_user2interface !== 1'b1 || dout_user2interface !== base + i || fifo_count !== 5'd1 ||
          rx_count !== tx_count + 32'(fifo_count) || rx_count !== i + 1) begin
        failures++;
        $display("FAIL stream[%0d]: vld=%b dout=%h cnt=%0d rx=%0d tx=%0d want 1 %h 1 %0d %0d",
                 i, vld_user2interface, dout_user2interface, fifo_count, rx_count, tx_count,
                 base + i, i + 1, i);
      end
    end
    vld_interface2user = 1'b0;
    ack_interface2user = 1'b0;
  endtask

  task automatic test_random_stall();
    int start_pops;
    do_reset();
    start_pops = pop_total;
    for (int c = 0; c < 10000; c++) begin
      vld_interface2user = ($urandom_range(0, 3) != 0);
      ack_interface2user = ($urandom_range(0, 3) != 0);
      din_leaf_interface2user = $urandom;
      tick();
      checks++;
      if (vld_user2interface !== (exp_q.size() != 0) || ack_user2interface !== (exp_q.size() != 16) ||
          fifo_count !== exp_q.size() || rx_count !== m_rx || tx_count !== m_tx ||
          (exp_q.size() != 0 && dout_user2interface !== exp_q[0])) begin
        failures++;
        $display("FAIL random[%0d]: vld=%b ack=%b cnt=%0d rx=%0d tx=%0d dout=%h want %b %b %0d %0d %0d %h",
                 c, vld_user2interface, ack_user2interface, fifo_count, rx_count, tx_count,
                 dout_user2interface, exp_q.size() != 0, exp_q.size() != 16, exp_q.size(),
                 m_rx, m_tx, (exp_q.size() != 0) ? exp_q[0] : 32'd0);
      end
      if (c == 5000) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        exp_q.delete();
        m_rx = 0;
        m_tx = 0;
      end
    end
    checks++;
    if ((pop_total - start_pops) / 16 <= 100) begin
      failures++;
      $display("FAIL random_wraps: pointer wraps=%0d want >100", (pop_total - start_pops) / 16);
    end
    vld_interface2user = 1'b0;
    ack_interface2user = 1'b0;
  endtask

  initial begin
    pop_total = 0;
    m_rx = 0;
    m_tx = 0;
    test_reset();
    test_single();
    test_fill_and_full_pop();
    test_streaming();
    test_random_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
